// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared widths and payload types for the FP normaliser
// Default widths plus the stage-1 payload and result structs for the
// default configuration (FRAC_W_DEF / EXP_W_DEF).
package fp_norm_pkg;

    localparam int FRAC_W_DEF  = 33;
    localparam int EXP_W_DEF   = 8;
    localparam int SHIFT_W_DEF = $clog2(FRAC_W_DEF + 1);

    // Stage-1 payload: magnitude, its leading-zero count, exponent, sign, zero.
    typedef struct packed {
        logic [FRAC_W_DEF-1:0]  mag;
        logic [SHIFT_W_DEF-1:0] lzc;
        logic [EXP_W_DEF-1:0]   exp;
        logic                   sign;
        logic                   zero;
    } s1_t;

    // Normalised result as presented on out_*.
    typedef struct packed {
        logic [FRAC_W_DEF-1:0]  frac;
        logic [EXP_W_DEF-1:0]   exp;
        logic                   sign;
        logic [SHIFT_W_DEF-1:0] shift;
        logic                   zero;
        logic                   uf;
    } norm_res_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational tree leading-zero counter
// Ports:
//   din  in  WIDTH   value to scan (MSB first)
//   cnt  out CNT_W   number of leading zeros; WIDTH when din is all zero
// WIDTH must be at least 2.
module fp_lzc #(
    parameter  int WIDTH = 33,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    localparam int LVLS = $clog2(WIDTH);
    localparam int P    = 1 << LVLS;

    logic [P-1:0]      din_p;
    logic [P-1:0]      v_lvl [LVLS+1];
    logic [LVLS-1:0]   c_lvl [LVLS+1][P];

    always_comb begin
        // Pad below the LSB with ones: an all-zero din then counts exactly
        // WIDTH zeros before hitting the padding.
        din_p = '1;
        din_p[P-1 -: WIDTH] = din;

        for (int l = 0; l <= LVLS; l++) begin
            v_lvl[l] = '0;
            for (int i = 0; i < P; i++) begin
                c_lvl[l][i] = '0;
            end
        end

        for (int i = 0; i < P; i++) begin
            v_lvl[0][i] = din_p[i];
        end

        // Each node covers 2^l bits; if its upper half is empty the count is
        // the half size plus the count of the lower half.
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (P >> l); i++) begin
                v_lvl[l][i] = v_lvl[l-1][2*i+1] | v_lvl[l-1][2*i];
                if (v_lvl[l-1][2*i+1]) begin
                    c_lvl[l][i] = c_lvl[l-1][2*i+1];
                end else begin
                    c_lvl[l][i] = c_lvl[l-1][2*i] + (LVLS'(1) << (l - 1));
                end
            end
        end

        cnt = v_lvl[LVLS][0] ? CNT_W'(c_lvl[LVLS][0]) : CNT_W'(WIDTH);
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - two-stage leading-zero normaliser for FP add/sub
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_frac/exp/sign/neg     raw fraction (maybe two's-complement), exponent, sign
//   out_valid/out_ready      output handshake
//   out_frac/exp/sign        normalised fraction, adjusted exponent, corrected sign
//   out_shift                left shift applied
//   out_zero/out_uf          zero result / exponent underflow (flushed to zero)
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter  int FRAC_W  = FRAC_W_DEF,
    parameter  int EXP_W   = EXP_W_DEF,
    localparam int SHIFT_W = $clog2(FRAC_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAC_W-1:0]  in_frac,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic               in_sign,
    input  logic               in_neg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAC_W-1:0]  out_frac,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_sign,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_zero,
    output logic               out_uf
);

    localparam int CMP_W = ((EXP_W > SHIFT_W) ? EXP_W : SHIFT_W) + 1;

    typedef struct packed {
        logic [FRAC_W-1:0]  mag;
        logic [SHIFT_W-1:0] lzc;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic               zero;
    } stage1_t;

    typedef struct packed {
        logic [FRAC_W-1:0]  frac;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic [SHIFT_W-1:0] shift;
        logic               zero;
        logic               uf;
    } stage2_t;

    logic               s1_v_q, s1_v_d;
    logic               s2_v_q, s2_v_d;
    stage1_t            s1_q, s1_d;
    stage2_t            s2_q, s2_d;
    logic               adv1, adv2;
    logic [FRAC_W-1:0]  mag;
    logic [SHIFT_W-1:0] lzc;

    assign mag = in_neg ? (~in_frac + FRAC_W'(1)) : in_frac;

    fp_lzc #(.WIDTH(FRAC_W)) u_lzc (
        .din (mag),
        .cnt (lzc)
    );

    always_comb begin
        adv2   = ~s2_v_q | out_ready;
        adv1   = ~s1_v_q | adv2;

        s1_v_d = adv1 ? in_valid : s1_v_q;
        s1_d   = s1_q;
        if (adv1 && in_valid) begin
            s1_d.mag  = mag;
            s1_d.lzc  = lzc;
            s1_d.exp  = in_exp;
            s1_d.sign = in_sign ^ in_neg;
            s1_d.zero = (mag == '0);
        end

        s2_v_d = adv2 ? s1_v_q : s2_v_q;
        s2_d   = s2_q;
        if (adv2 && s1_v_q) begin
            s2_d      = '0;
            s2_d.sign = s1_q.sign;
            if (s1_q.zero) begin
                s2_d.zero = 1'b1;
            end else if (CMP_W'(s1_q.lzc) >= CMP_W'(s1_q.exp)) begin
                // Normalising would drive the biased exponent to 0 or below.
                s2_d.zero  = 1'b1;
                s2_d.uf    = 1'b1;
                s2_d.shift = s1_q.lzc;
            end else begin
                s2_d.frac  = s1_q.mag << s1_q.lzc;
                s2_d.exp   = s1_q.exp - EXP_W'(s1_q.lzc);
                s2_d.shift = s1_q.lzc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_v_q;
    assign out_frac  = s2_q.frac;
    assign out_exp   = s2_q.exp;
    assign out_sign  = s2_q.sign;
    assign out_shift = s2_q.shift;
    assign out_zero  = s2_q.zero;
    assign out_uf    = s2_q.uf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - randomized scoreboard bench for fp_norm_pipe
module tb_fp_norm_pipe;
    import fp_norm_pkg::*;

    localparam int FW = FRAC_W_DEF;
    localparam int EW = EXP_W_DEF;
    localparam int SW = SHIFT_W_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_frac;
    logic [EW-1:0] in_exp;
    logic          in_sign;
    logic          in_neg;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_frac;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic [SW-1:0] out_shift;
    logic          out_zero;
    logic          out_uf;

    int        n_cmp = 0;
    int        n_bad = 0;
    int        n_out = 0;
    bit        saw_block = 0;
    norm_res_t exp_q[$];

    fp_norm_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frac   (in_frac),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frac  (out_frac),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_shift (out_shift),
        .out_zero  (out_zero),
        .out_uf    (out_uf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: magnitude modulo 2^FW, leading zeros from the bit length.
    function automatic norm_res_t model(input logic [FW-1:0] f, input logic [EW-1:0] e,
                                        input logic s, input logic n);
        norm_res_t       r;
        longint unsigned full, fz, m;
        int              bl, lz;
        full = longint'(1) << FW;
        fz   = {31'd0, f};
        m    = n ? ((full - fz) % full) : fz;
        bl   = 0;
        while ((m >> bl) != 0) bl++;
        lz     = FW - bl;
        r      = '0;
        r.sign = s ^ n;
        if (m == 0) begin
            r.zero = 1'b1;
        end else if (lz >= int'(e)) begin
            r.zero  = 1'b1;
            r.uf    = 1'b1;
            r.shift = SW'(lz);
        end else begin
            r.frac  = FW'(m << lz);
            r.exp   = EW'(int'(e) - lz);
            r.shift = SW'(lz);
        end
        return r;
    endfunction

    // Scoreboard: every valid cycle is compared against the queue head, so a
    // stalled beat must hold the expected payload until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb.extra_beat", 1, 0);
                end else begin
                    check("sb.frac",  out_frac,  exp_q[0].frac);
                    check("sb.exp",   out_exp,   exp_q[0].exp);
                    check("sb.sign",  out_sign,  exp_q[0].sign);
                    check("sb.shift", out_shift, exp_q[0].shift);
                    check("sb.zero",  out_zero,  exp_q[0].zero);
                    check("sb.uf",    out_uf,    exp_q[0].uf);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_frac, in_exp, in_sign, in_neg));
            if (in_valid && !in_ready) saw_block = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [FW-1:0] f, input logic [EW-1:0] e,
                             input logic s, input logic n);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_frac  = f;
        in_exp   = e;
        in_sign  = s;
        in_neg   = n;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic run_directed(input string tag, input logic [FW-1:0] f, input logic [EW-1:0] e,
                                input logic s, input logic n, input logic [FW-1:0] wf,
                                input logic [EW-1:0] we, input logic ws, input logic [SW-1:0] wsh,
                                input logic wz, input logic wuf);
        send_beat(f, e, s, n);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".frac"},  out_frac,  wf);
        check({tag, ".exp"},   out_exp,   we);
        check({tag, ".sign"},  out_sign,  ws);
        check({tag, ".shift"}, out_shift, wsh);
        check({tag, ".zero"},  out_zero,  wz);
        check({tag, ".uf"},    out_uf,    wuf);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rand_frac();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {1'b1, {(FW-1){1'b0}}};
            2:       return FW'(r);
            default: return FW'(r) >> $urandom_range(0, FW);
        endcase
    endfunction

    initial begin
        int  base;
        bit  done;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_frac   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        in_neg    = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst.out_valid", out_valid, 0);
        check("rst.out_frac",  out_frac,  0);
        check("rst.out_exp",   out_exp,   0);
        check("rst.out_shift", out_shift, 0);
        check("rst.flags",     {out_sign, out_zero, out_uf}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        run_directed("aligned",  33'h1_8000_0000, 8'd130, 1'b0, 1'b0, 33'h1_8000_0000, 8'd130, 1'b0, 6'd0,  1'b0, 1'b0);
        run_directed("shift24",  33'h0_0000_0100, 8'd130, 1'b0, 1'b0, 33'h1_0000_0000, 8'd106, 1'b0, 6'd24, 1'b0, 1'b0);
        run_directed("neg_one",  33'h1_FFFF_FFFF, 8'd100, 1'b0, 1'b1, 33'h1_0000_0000, 8'd68,  1'b1, 6'd32, 1'b0, 1'b0);
        run_directed("zero",     33'h0,           8'd77,  1'b1, 1'b0, 33'h0,           8'd0,   1'b1, 6'd0,  1'b1, 1'b0);
        run_directed("uf32",     33'h0_0000_0001, 8'd20,  1'b0, 1'b0, 33'h0,           8'd0,   1'b0, 6'd32, 1'b1, 1'b1);
        run_directed("most_neg", 33'h1_0000_0000, 8'd50,  1'b0, 1'b1, 33'h1_0000_0000, 8'd50,  1'b1, 6'd0,  1'b0, 1'b0);
        run_directed("uf_eq",    33'h0_0000_0100, 8'd24,  1'b0, 1'b0, 33'h0,           8'd0,   1'b0, 6'd24, 1'b1, 1'b1);
        run_directed("uf_edge",  33'h0_0000_0100, 8'd25,  1'b0, 1'b0, 33'h1_0000_0000, 8'd1,   1'b0, 6'd24, 1'b0, 1'b0);

        // Four back-to-back beats with a 3-cycle stall after the first output.
        saw_block = 1'b0;
        base      = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat(rand_frac(), EW'($urandom_range(40, 255)), 1'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("bp.in_ready_dropped", saw_block, 1);
        check("bp.beats_out", n_out - base, 4);
        check("bp.queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset with both stages full: outputs clear without a clock edge.
        out_ready = 1'b0;
        send_beat(33'h0_0001_2345, 8'd99, 1'b0, 1'b0);
        send_beat(33'h1_2345_6789, 8'd99, 1'b1, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst.full", {out_valid, in_ready}, 2'b10);
        #2 rst = 1'b0;
        #1;
        check("mid_rst.out_valid", out_valid, 0);
        check("mid_rst.out_data",  {out_frac, out_exp, out_shift}, 0);
        check("mid_rst.out_flags", {out_sign, out_zero, out_uf}, 0);
        check("mid_rst.in_ready",  in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_directed("post_rst", 33'h0_0000_0C00, 8'd200, 1'b0, 1'b0, 33'h1_8000_0000, 8'd179, 1'b0, 6'd21, 1'b0, 1'b0);

        // Randomized traffic with random gaps and random backpressure.
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_beat(rand_frac(),
                              ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255)),
                              1'($urandom), 1'($urandom));
                end
                in_valid = 1'b0;
                done     = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("rand.beats_out", n_out - base, 300);
        check("rand.queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
